// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, fetch entry type and pc step for the 16-bit cpu
package cpu_pkg;

    localparam int WORD_W = 16;
    localparam int PC_W   = 16;

    localparam logic [PC_W-1:0] PC_STEP = 16'd2;

    typedef struct packed {
        logic [WORD_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - synchronous fifo of fetched {inst, pc} entries with clear
module inst_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic [AW:0]  count,
    output fetch_entry_t head
);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    // Storage is zeroed on reset so the head is defined before the first push.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - pc generation, fixed-latency imem pipe, credit issue and redirect
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              QDEPTH      = 4,
    parameter int              MEM_LATENCY = 2,
    parameter logic [PC_W-1:0] RESET_PC    = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              fetch_stall,
    output logic [PC_W-2:0]   imem_raddr,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [PC_W-1:0]        fetch_pc;
    logic [MEM_LATENCY-1:0] slot_valid;
    logic [PC_W-1:0]        slot_pc [MEM_LATENCY];

    logic [CW-1:0] q_count;
    logic [CW:0]   inflight_cnt;
    logic          credit_ok;
    logic          issue;
    logic          push;
    logic          pop;
    fetch_entry_t  push_data;
    fetch_entry_t  head;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + (CW+1)'(slot_valid[i]);
        end
    end

    // Credit ignores a same-cycle pop, so the fifo can never be overfilled.
    assign credit_ok = ({1'b0, q_count} + inflight_cnt) < (CW+1)'(QDEPTH);
    assign issue     = !reset && !fetch_stall && credit_ok;

    assign imem_raddr = redirect_valid ? redirect_pc[PC_W-1:1] : fetch_pc[PC_W-1:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            slot_valid <= '0;
        end else if (redirect_valid) begin
            fetch_pc   <= (redirect_pc & 16'hFFFE) + PC_STEP;
            slot_valid <= MEM_LATENCY'(1);
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            slot_valid <= MEM_LATENCY'({slot_valid, issue});
        end
    end

    // Slot pcs are only meaningful alongside their valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        slot_pc[0] <= redirect_valid ? (redirect_pc & 16'hFFFE) : fetch_pc;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            slot_pc[i] <= slot_pc[i-1];
        end
    end

    assign push      = slot_valid[MEM_LATENCY-1] && !redirect_valid;
    assign push_data = '{inst: imem_rdata, pc: slot_pc[MEM_LATENCY-1]};
    assign out_valid = (q_count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;

    inst_fifo #(
        .DEPTH (QDEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (q_count),
        .head      (head)
    );

    assign out_inst = head.inst;
    assign out_pc   = head.pc;

endmodule
